ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register. It sits directly downstream of the ID/EX register and consumes its outputs: PC, rs1/rs2/rd, immediate, operands, funct4, and the Branch/Memread/Memtoreg/Memwrite/Regwrite/Alusrc/aluop controls.
- It performs operand forwarding selection, ALU-control decode, ALU evaluation, branch comparison and branch-target generation.
- It registers results for the MEM stage and supports stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- a_in  in  XLEN  PC of the instruction in EX.
- readdata1_in  in  XLEN  rs1 value from ID/EX.
- readdata2_in  in  XLEN  rs2 value from ID/EX.
- imm_data_in  in  XLEN  sign-extended immediate.
- rd_in  in  REGW  destination register.
- funct4_in  in  4  {instr[30], funct3}.
- aluop_in  in  2  00 add, 01 branch, 10 R-type, 11 I-type.
- branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in  in  1 each  controls from ID/EX.
- fwd_a, fwd_b  in  2 each  00 ID/EX value, 10 EX/MEM alu_result, 01 MEM/WB writeback data, 11 treated as 00.
- wb_data_in  in  XLEN  MEM/WB writeback value.
- stall  in  1  hold EX/MEM contents.
- flush  in  1  load a bubble into EX/MEM.
- alu_result  out  XLEN  registered ALU result.
- write_data  out  XLEN  registered forwarded rs2 (store data).
- branch_target  out  XLEN  registered a_in + imm_data_in.
- branch_taken  out  1  registered branch decision.
- rd  out  REGW  registered destination.
- Memread, Memtoreg, Memwrite, Regwrite  out  1 each  registered controls.
- zero  out  1  registered (ALU result == 0).

Behaviour:
- Operand A = fwd_a mux. Store data = fwd_b mux. Operand B = imm_data_in if alusrc_in, else the fwd_b mux. The alu_result used for EX/MEM forwarding is this block's own registered output.
- ALU control:
  - aluop 00: add.
  - aluop 01: subtract.
  - aluop 10, funct4: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra, 0010 slt, 0011 sltu.
  - aluop 11: same table, except bit3 is ignored for all codes other than x101 (so 1000 gives add).
  - Unlisted codes give add.
- Shift amount = operand B[4:0]. slt is signed, sltu unsigned; both yield 0/1 zero-extended. All arithmetic wraps modulo 2^XLEN; no overflow flag.
- Branch condition applies when branch_in=1, from funct4[2:0] on A vs store-data operand: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu. 010 and 011 are never taken. branch_taken = branch_in AND condition.
- branch_target = a_in + imm_data_in. It is computed and registered regardless of branch_in.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Register update priority, highest first:
  - reset=0: all outputs 0 immediately (async) and held while low. Release is synchronous to the next edge.
  - flush=1: Memread, Memwrite, Regwrite, Memtoreg, branch_taken and rd go to 0. Data outputs go to 0.
  - stall=1: all outputs hold.
  - otherwise: load the new values.
- flush and stall together: flush wins.
- Reset mid-operation discards the in-flight instruction. No state survives.
- rd_in=0 with regwrite_in=1: passed through unchanged. Suppressing x0 writes is the register file's job.

Test Plan:
- Reset low for 2 cycles with nonzero inputs -> every output 0 while low. After release, first edge loads inputs.
- aluop=10, funct4=1000, rs1=5, rs2=7, fwd=00 -> alu_result=0xFFFFFFFE, zero=0, one cycle later.
- aluop=10, funct4=1101, rs1=0x80000000, rs2=4 -> 0xF8000000. funct4=0101 -> 0x08000000. aluop=11, funct4=1000, imm=3, alusrc=1, rs1=10 -> 13.
- Forwarding: fwd_a=10 with previous result 0x20, fwd_b=01 with wb_data_in=0x5, aluop=10, funct4=0000 -> 0x25. Then fwd_b=11 with rs2=1 -> 0x21.
- Branch: a_in=0x100, imm=0x10, branch_in=1, funct4=x100, rs1=-1, rs2=1 -> branch_taken=1, target=0x110. funct4=x110, same operands -> branch_taken=0.
- Stall 3 cycles with changing inputs -> outputs frozen. Assert stall and flush together -> Regwrite=Memwrite=Memread=branch_taken=0, rd=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU-control decode, ALU, branch compare and
// target generation, followed by the EX/MEM pipeline register with stall/flush.
module ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] readdata1_in,
  input  logic [XLEN-1:0] readdata2_in,
  input  logic [XLEN-1:0] imm_data_in,
  input  logic [REGW-1:0] rd_in,
  input  logic [3:0]      funct4_in,
  input  logic [1:0]      aluop_in,
  input  logic            branch_in,
  input  logic            memread_in,
  input  logic            memtoreg_in,
  input  logic            memwrite_in,
  input  logic            regwrite_in,
  input  logic            alusrc_in,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] branch_target,
  output logic            branch_taken,
  output logic [REGW-1:0] rd,
  output logic            Memread,
  output logic            Memtoreg,
  output logic            Memwrite,
  output logic            Regwrite,
  output logic            zero
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  logic [XLEN-1:0] op_a, store_d, op_b, alu_d, target_d;
  logic [3:0]      fcode;
  alu_op_e         alu_op;
  logic [4:0]      shamt;
  logic            eq, lt_s, lt_u, cond, taken_d;

  logic [XLEN-1:0] alu_q, wdata_q, target_q;
  logic [REGW-1:0] rd_q;
  logic            taken_q, memread_q, memtoreg_q, memwrite_q, regwrite_q, zero_q;

  // EX/MEM forwarding uses this stage's own registered result
  always_comb begin
    op_a    = readdata1_in;
    store_d = readdata2_in;
    case (fwd_a)
      2'b10:   op_a = alu_q;
      2'b01:   op_a = wb_data_in;
      default: op_a = readdata1_in;
    endcase
    case (fwd_b)
      2'b10:   store_d = alu_q;
      2'b01:   store_d = wb_data_in;
      default: store_d = readdata2_in;
    endcase
    op_b = alusrc_in ? imm_data_in : store_d;
  end

  // I-type only keeps bit3 to separate srai from srli
  always_comb begin
    fcode  = funct4_in;
    alu_op = ALU_ADD;
    if (aluop_in == 2'b11)
      fcode = {funct4_in[3] & (funct4_in[2:0] == 3'b101), funct4_in[2:0]};
    case (aluop_in)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      default: begin
        case (fcode)
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0111: alu_op = ALU_AND;
          4'b0110: alu_op = ALU_OR;
          4'b0100: alu_op = ALU_XOR;
          4'b0001: alu_op = ALU_SLL;
          4'b0101: alu_op = ALU_SRL;
          4'b1101: alu_op = ALU_SRA;
          4'b0010: alu_op = ALU_SLT;
          4'b0011: alu_op = ALU_SLTU;
          default: alu_op = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    shamt = op_b[4:0];
    alu_d = op_a + op_b;
    case (alu_op)
      ALU_ADD:  alu_d = op_a + op_b;
      ALU_SUB:  alu_d = op_a - op_b;
      ALU_AND:  alu_d = op_a & op_b;
      ALU_OR:   alu_d = op_a | op_b;
      ALU_XOR:  alu_d = op_a ^ op_b;
      ALU_SLL:  alu_d = op_a << shamt;
      ALU_SRL:  alu_d = op_a >> shamt;
      ALU_SRA:  alu_d = XLEN'($signed(op_a) >>> shamt);
      ALU_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_d = op_a + op_b;
    endcase
  end

  // Branch compares rs1 against rs2 (store-data path), never the immediate
  always_comb begin
    eq   = (op_a == store_d);
    lt_s = ($signed(op_a) < $signed(store_d));
    lt_u = (op_a < store_d);
    cond = 1'b0;
    case (funct4_in[2:0])
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
    taken_d  = branch_in & cond;
    target_d = a_in + imm_data_in;
  end

  // EX/MEM register: reset > flush > stall > load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      alu_q      <= '0;
      wdata_q    <= '0;
      target_q   <= '0;
      taken_q    <= 1'b0;
      rd_q       <= '0;
      memread_q  <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (!stall) begin
      alu_q      <= alu_d;
      wdata_q    <= store_d;
      target_q   <= target_d;
      taken_q    <= taken_d;
      rd_q       <= rd_in;
      memread_q  <= memread_in;
      memtoreg_q <= memtoreg_in;
      memwrite_q <= memwrite_in;
      regwrite_q <= regwrite_in;
      zero_q     <= (alu_d == '0);
    end
  end

  assign alu_result    = alu_q;
  assign write_data    = wdata_q;
  assign branch_target = target_q;
  assign branch_taken  = taken_q;
  assign rd            = rd_q;
  assign Memread       = memread_q;
  assign Memtoreg      = memtoreg_q;
  assign Memwrite      = memwrite_q;
  assign Regwrite      = regwrite_q;
  assign zero          = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors checked with
// immediate assertions one cycle after each load edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in, readdata1_in, readdata2_in, imm_data_in, wb_data_in;
  logic [4:0]  rd_in;
  logic [3:0]  funct4_in;
  logic [1:0]  aluop_in, fwd_a, fwd_b;
  logic        branch_in, memread_in, memtoreg_in, memwrite_in, regwrite_in, alusrc_in;
  logic        stall, flush;
  logic [31:0] alu_result, write_data, branch_target;
  logic        branch_taken, Memread, Memtoreg, Memwrite, Regwrite, zero;
  logic [4:0]  rd;

  int n_chk  = 0;
  int n_fail = 0;

  ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .readdata1_in(readdata1_in),
    .readdata2_in(readdata2_in), .imm_data_in(imm_data_in), .rd_in(rd_in),
    .funct4_in(funct4_in), .aluop_in(aluop_in), .branch_in(branch_in),
    .memread_in(memread_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .regwrite_in(regwrite_in), .alusrc_in(alusrc_in), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_data_in(wb_data_in), .stall(stall), .flush(flush),
    .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
    .branch_taken(branch_taken), .rd(rd), .Memread(Memread), .Memtoreg(Memtoreg),
    .Memwrite(Memwrite), .Regwrite(Regwrite), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, Memread, Memtoreg, Memwrite, Regwrite, branch_taken, zero}, {26'd0, exp});
  endtask

  task automatic alu_vec(input logic [1:0] op, input logic [3:0] f, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic src);
    aluop_in = op; funct4_in = f; readdata1_in = r1; readdata2_in = r2;
    imm_data_in = imm; alusrc_in = src;
  endtask

  initial begin
    // Reset held low with every input nonzero
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    a_in = 32'h40; imm_data_in = 32'h8; wb_data_in = 32'h77; rd_in = 5'd3;
    readdata1_in = 32'h11; readdata2_in = 32'h22; funct4_in = 4'b1000; aluop_in = 2'b10;
    branch_in = 1'b1; memread_in = 1'b1; memtoreg_in = 1'b1; memwrite_in = 1'b1;
    regwrite_in = 1'b1; alusrc_in = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    tick();
    tick();
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_target", branch_target, 32'h0);
    chk("rst_rd", {27'd0, rd}, 32'h0);
    chk_ctrl("rst_ctrl", 6'b000000);

    // First edge after release loads: 5 - 7
    branch_in = 1'b0; memread_in = 1'b0; memtoreg_in = 1'b0; memwrite_in = 1'b0;
    alu_vec(2'b10, 4'b1000, 32'd5, 32'd7, 32'h8, 1'b0);
    reset = 1'b1;
    tick();
    chk("sub_alu", alu_result, 32'hFFFF_FFFE);
    chk("sub_wdata", write_data, 32'd7);
    chk("sub_target", branch_target, 32'h48);
    chk("sub_rd", {27'd0, rd}, 32'd3);
    chk_ctrl("sub_ctrl", 6'b000100);

    alu_vec(2'b10, 4'b1101, 32'h8000_0000, 32'd4, 32'h8, 1'b0);
    tick();
    chk("sra", alu_result, 32'hF800_0000);
    alu_vec(2'b10, 4'b0101, 32'h8000_0000, 32'd4, 32'h8, 1'b0);
    tick();
    chk("srl", alu_result, 32'h0800_0000);
    alu_vec(2'b11, 4'b1000, 32'd10, 32'd99, 32'd3, 1'b1);
    tick();
    chk("addi_b3", alu_result, 32'd13);
    chk("addi_wdata", write_data, 32'd99);
    alu_vec(2'b11, 4'b1101, 32'h8000_0000, 32'd0, 32'h0000_0404, 1'b1);
    tick();
    chk("srai", alu_result, 32'hF800_0000);
    alu_vec(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    tick();
    chk("slt", alu_result, 32'd1);
    alu_vec(2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    tick();
    chk("sltu", alu_result, 32'd0);
    chk("sltu_zero", {31'd0, zero}, 32'd1);
    alu_vec(2'b10, 4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0);
    tick();
    chk("and", alu_result, 32'h00F0_1200);

    // Forwarding from own result and from writeback
    alu_vec(2'b00, 4'b0000, 32'h20, 32'h0, 32'h0, 1'b0);
    tick();
    chk("fwd_seed", alu_result, 32'h20);
    fwd_a = 2'b10; fwd_b = 2'b01; wb_data_in = 32'h5;
    alu_vec(2'b10, 4'b0000, 32'hDEAD, 32'h99, 32'h0, 1'b0);
    tick();
    chk("fwd_alu", alu_result, 32'h25);
    chk("fwd_wdata", write_data, 32'h5);
    fwd_a = 2'b11; fwd_b = 2'b11;
    alu_vec(2'b10, 4'b0000, 32'h20, 32'h1, 32'h0, 1'b0);
    tick();
    chk("fwd_11", alu_result, 32'h21);
    fwd_a = 2'b00; fwd_b = 2'b00;

    // Branches
    a_in = 32'h100; branch_in = 1'b1;
    alu_vec(2'b01, 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
    tick();
    chk("blt_taken", {31'd0, branch_taken}, 32'd1);
    chk("blt_target", branch_target, 32'h110);
    alu_vec(2'b01, 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
    tick();
    chk("bltu_taken", {31'd0, branch_taken}, 32'd0);
    alu_vec(2'b01, 4'b0010, 32'd7, 32'd7, 32'h10, 1'b0);
    tick();
    chk("b010_taken", {31'd0, branch_taken}, 32'd0);
    chk("b010_zero", {31'd0, zero}, 32'd1);

    // Load a full-control instruction, then stall with changing inputs
    memread_in = 1'b1; memtoreg_in = 1'b1; memwrite_in = 1'b1; regwrite_in = 1'b1;
    rd_in = 5'd9; a_in = 32'h200;
    alu_vec(2'b00, 4'b0000, 32'd1, 32'd1, 32'h4, 1'b0);
    tick();
    chk("beq_alu", alu_result, 32'd2);
    chk("beq_target", branch_target, 32'h204);
    chk_ctrl("beq_ctrl", 6'b111110);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_in = 5'(i + 20); a_in = 32'(i * 64);
      alu_vec(2'b10, 4'b0110, 32'(i + 100), 32'h55, 32'h1, 1'b0);
      tick();
      chk("stall_alu", alu_result, 32'd2);
      chk("stall_rd", {27'd0, rd}, 32'd9);
      chk("stall_target", branch_target, 32'h204);
    end
    flush = 1'b1;
    tick();
    chk("flush_ctrl", {26'd0, Memread, Memtoreg, Memwrite, Regwrite, branch_taken, 1'b0}, 32'd0);
    chk("flush_rd", {27'd0, rd}, 32'd0);
    chk("flush_alu", alu_result, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // rd=0 passes through; then async reset mid-operation
    rd_in = 5'd0; regwrite_in = 1'b1; branch_in = 1'b0;
    alu_vec(2'b10, 4'b0100, 32'hFF00, 32'h0F0F, 32'h0, 1'b0);
    tick();
    chk("xor", alu_result, 32'hF00F);
    chk("x0_regwrite", {31'd0, Regwrite}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_alu", alu_result, 32'd0);
    chk("async_regwrite", {31'd0, Regwrite}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_alu", alu_result, 32'hF00F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
